adc128s_spi_model: RTL and testbench
====================================

Name: adc128s_spi_model

Overview:
- Behavioural/synthesizable model of an 8-channel, 12-bit SPI A2D converter in the style of the ADC128S.
- Sits on the A2D SPI bus as the slave and returns load-cell, steering-pot and battery readings to the Segway controller's A2D interface.
- All logic runs in the system clock domain; the SPI inputs are oversampled and edge-detected.

Parameters:
- None.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- SS_n  input  1  SPI slave select, active low.
- SCLK  input  1  SPI clock from master; idles high.
- MOSI  input  1  command data from master.
- MISO  output  1  response data to master.
- ld_cell_lft  input  12  analog value for channel 0.
- ld_cell_rght  input  12  analog value for channel 4.
- steerPot  input  12  analog value for channel 5.
- batt  input  12  analog value for channel 6.

Behaviour:
- Input conditioning:
  - SS_n, SCLK and MOSI each pass through a 2-flop synchronizer.
  - A third SCLK flop provides edge detection: rise = sync high and prev low; fall = sync low and prev high.
- Transaction framing:
  - Always exactly 16 SCLK rising edges per transaction, MSB first.
  - A frame starts on the synchronized SS_n falling edge and ends on the SS_n rising edge.
- Receive path:
  - On each SCLK rise while SS_n is low, shift MOSI into the 16-bit rx_shft LSB.
  - Command format is {2'b00, chnl[2:0], 11'bx}; only bits [13:11] are used.
- Transmit path:
  - On SS_n fall, load tx_shft = {4'h0, resp[11:0]}, where resp is the value captured at the end of the previous frame.
  - MISO = tx_shft[15].
  - On each SCLK fall that follows at least one rise in the current frame, shift tx_shft left and fill with 0. The first fall, before any rise, does not shift.
- Pipelining:
  - On SS_n rise, chnl is latched from rx_shft[13:11].
  - The selected input is sampled into resp in that same cycle, so the data appears on the next frame (one-frame latency).
- Channel map: 0 -> ld_cell_lft; 4 -> ld_cell_rght; 5 -> steerPot; 6 -> batt; 1, 2, 3, 7 -> 12'h000.
- Idle and short frames:
  - MISO shows tx_shft[15] whenever SS_n is high (no tri-state).
  - If SS_n rises after fewer than 16 rises, the partial rx_shft is still decoded. Masters must not rely on this.
- Reset values (rst high at a posedge): rx_shft=0, tx_shft=0, chnl=0, resp=0, MISO=0, all synchronizer flops = 1 (SS_n/SCLK idle high), bit counter=0.
- Reset mid-frame: the frame is aborted and the next SS_n fall begins a fresh frame. The first frame after reset returns 16'h0000.
- Simultaneous events:
  - SS_n rise has priority over any SCLK edge in the same cycle.
  - Input values are sampled at the SS_n-rise cycle; later changes do not affect the pending response.
- Minimum SCLK half-period supported: 4 clk cycles.

Test Plan:
- Reset, then frame 1 with command 16'h0000 (ch0), ld_cell_lft=12'hABC -> MISO word 16'h0000. Frame 2 with any command -> 16'h0ABC.
- Frame with command 16'h2000 (ch4), ld_cell_rght=12'h123; next frame with command 16'h2800 (ch5), steerPot=12'h456 -> frame 2 returns 16'h0123; frame 3 returns 16'h0456.
- Command 16'h3000 (ch6), batt=12'hFFF, then change batt to 12'h000 after SS_n rises -> next frame returns 16'h0FFF.
- Command 16'h0800 (ch1) with all inputs 12'hFFF -> next frame returns 16'h0000.
- Assert rst after 7 SCLK rises of a frame, then run a full frame requesting ch0 with ld_cell_lft=12'h5A5 -> that frame returns 16'h0000; the following frame returns 16'h05A5.
- Hold SS_n high while toggling SCLK 16 times -> no shifting; the next frame still returns the previously pending response.

Source files
------------

// File: rtl/adc128s_spi_model.sv
// SPI slave model of an 8-channel, 12-bit A2D converter (ADC128S style).
// Oversamples the SPI pins in the clk domain; the response to a command appears one frame later.
//
// state | meaning
// IDLE  | SS_n high, no frame in progress; waiting for SS_n fall
// SHIFT | frame open; shifting MOSI in on SCLK rise, MISO out on SCLK fall

module adc128s_spi_model (
   input  logic        clk,
   input  logic        rst,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   input  logic [11:0] ld_cell_lft,
   input  logic [11:0] ld_cell_rght,
   input  logic [11:0] steerPot,
   input  logic [11:0] batt
);

   typedef enum logic [0:0] {IDLE, SHIFT} state_t;

   state_t      state, state_nxt;

   logic        ss_n_ff1, ss_n_ff2, ss_n_ff3;
   logic        sclk_ff1, sclk_ff2, sclk_ff3;
   logic        mosi_ff1, mosi_ff2;

   logic [15:0] rx_shft;
   logic [15:0] tx_shft;
   logic [2:0]  chnl;
   logic [11:0] resp;
   logic [11:0] resp_sel;
   logic [4:0]  rise_cnt;

   logic        ss_fall, ss_rise;
   logic        sclk_rise, sclk_fall;
   logic        rise_seen;

   logic        load_tx, shift_rx, shift_tx, latch_resp;

   // Two-flop synchronizers plus a third flop for edge detection; idle high.
   always_ff @(posedge clk) begin
      if (rst) begin
         ss_n_ff1 <= 1'b1;
         ss_n_ff2 <= 1'b1;
         ss_n_ff3 <= 1'b1;
         sclk_ff1 <= 1'b1;
         sclk_ff2 <= 1'b1;
         sclk_ff3 <= 1'b1;
         mosi_ff1 <= 1'b1;
         mosi_ff2 <= 1'b1;
      end else begin
         ss_n_ff1 <= SS_n;
         ss_n_ff2 <= ss_n_ff1;
         ss_n_ff3 <= ss_n_ff2;
         sclk_ff1 <= SCLK;
         sclk_ff2 <= sclk_ff1;
         sclk_ff3 <= sclk_ff2;
         mosi_ff1 <= MOSI;
         mosi_ff2 <= mosi_ff1;
      end
   end

   assign ss_fall   = ~ss_n_ff2 &  ss_n_ff3;
   assign ss_rise   =  ss_n_ff2 & ~ss_n_ff3;
   assign sclk_rise =  sclk_ff2 & ~sclk_ff3;
   assign sclk_fall = ~sclk_ff2 &  sclk_ff3;

   // Down-counter loaded at frame start; anything short of the load value
   // means at least one SCLK rise has happened in this frame.
   assign rise_seen = (rise_cnt != 5'd16);

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      load_tx    = 1'b0;
      shift_rx   = 1'b0;
      shift_tx   = 1'b0;
      latch_resp = 1'b0;
      case (state)
         IDLE: begin
            if (ss_fall) begin
               load_tx   = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            // SS_n rise wins over any SCLK edge seen in the same cycle.
            if (ss_rise) begin
               latch_resp = 1'b1;
               state_nxt  = IDLE;
            end else if (sclk_rise) begin
               shift_rx = 1'b1;
            end else if (sclk_fall && rise_seen) begin
               shift_tx = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         rise_cnt <= 5'd0;
      else if (load_tx)
         rise_cnt <= 5'd16;
      else if (shift_rx && (rise_cnt != 5'd0))
         rise_cnt <= rise_cnt - 5'd1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         rx_shft <= 16'h0000;
      else if (shift_rx)
         rx_shft <= {rx_shft[14:0], mosi_ff2};
   end

   always_ff @(posedge clk) begin
      if (rst)
         tx_shft <= 16'h0000;
      else if (load_tx)
         tx_shft <= {4'h0, resp};
      else if (shift_tx)
         tx_shft <= {tx_shft[14:0], 1'b0};
   end

   // Decode straight from rx_shft so the input is sampled on the SS_n-rise cycle.
   always_comb begin
      resp_sel = 12'h000;
      case (rx_shft[13:11])
         3'd0:    resp_sel = ld_cell_lft;
         3'd4:    resp_sel = ld_cell_rght;
         3'd5:    resp_sel = steerPot;
         3'd6:    resp_sel = batt;
         default: resp_sel = 12'h000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         chnl <= 3'd0;
         resp <= 12'h000;
      end else if (latch_resp) begin
         chnl <= rx_shft[13:11];
         resp <= resp_sel;
      end
   end

   assign MISO = tx_shft[15];

endmodule

// File: tb/tb_adc128s_spi_model.sv
// Directed bench for adc128s_spi_model: SPI master tasks drive frames and
// compare the returned MISO words against hand-computed values.

module tb_adc128s_spi_model;

   logic        clk;
   logic        rst;
   logic        SS_n;
   logic        SCLK;
   logic        MOSI;
   logic        MISO;
   logic [11:0] ld_cell_lft;
   logic [11:0] ld_cell_rght;
   logic [11:0] steerPot;
   logic [11:0] batt;

   int          n_vec;
   int          n_err;
   logic [15:0] rd_word;

   localparam int HALF = 8;

   adc128s_spi_model dut (
      .clk          (clk),
      .rst          (rst),
      .SS_n         (SS_n),
      .SCLK         (SCLK),
      .MOSI         (MOSI),
      .MISO         (MISO),
      .ld_cell_lft  (ld_cell_lft),
      .ld_cell_rght (ld_cell_rght),
      .steerPot     (steerPot),
      .batt         (batt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_val);
      n_vec++;
      if (obs !== exp_val) begin
         n_err++;
         $display("FAIL %s: got %04h expected %04h", tag, obs, exp_val);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One full 16-bit frame; MISO is sampled just before each SCLK rise.
   task automatic xfer(input logic [15:0] cmd, output logic [15:0] rd);
      rd = 16'h0000;
      SS_n = 1'b0;
      wait_clk(HALF);
      for (int i = 15; i >= 0; i--) begin
         SCLK = 1'b0;
         MOSI = cmd[i];
         wait_clk(HALF);
         rd[i] = MISO;
         SCLK = 1'b1;
         wait_clk(HALF);
      end
      SS_n = 1'b1;
      MOSI = 1'b1;
      wait_clk(2 * HALF);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b1;
      SS_n = 1'b1;
      SCLK = 1'b1;
      MOSI = 1'b1;
      ld_cell_lft  = 12'hABC;
      ld_cell_rght = 12'h000;
      steerPot     = 12'h000;
      batt         = 12'h000;
      wait_clk(4);
      chk("reset_miso", {15'd0, MISO}, 16'h0000);
      rst = 1'b0;
      wait_clk(4);

      xfer(16'h0000, rd_word);
      chk("first_frame", rd_word, 16'h0000);
      xfer(16'h0000, rd_word);
      chk("ch0_abc", rd_word, 16'h0ABC);

      ld_cell_rght = 12'h123;
      xfer(16'h2000, rd_word);
      chk("ch0_again", rd_word, 16'h0ABC);
      steerPot = 12'h456;
      xfer(16'h2800, rd_word);
      chk("ch4_123", rd_word, 16'h0123);
      batt = 12'hFFF;
      xfer(16'h3000, rd_word);
      chk("ch5_456", rd_word, 16'h0456);
      batt = 12'h000;
      ld_cell_lft = 12'h111;
      xfer(16'h0000, rd_word);
      chk("ch6_fff_held", rd_word, 16'h0FFF);

      ld_cell_lft  = 12'hFFF;
      ld_cell_rght = 12'hFFF;
      steerPot     = 12'hFFF;
      batt         = 12'hFFF;
      xfer(16'h0800, rd_word);
      chk("ch0_111", rd_word, 16'h0111);
      xfer(16'h3800, rd_word);
      chk("ch1_zero", rd_word, 16'h0000);
      xfer(16'h0000, rd_word);
      chk("ch7_zero", rd_word, 16'h0000);

      // Abort a frame with reset after 7 SCLK rises.
      SS_n = 1'b0;
      wait_clk(HALF);
      for (int i = 0; i < 7; i++) begin
         SCLK = 1'b0;
         MOSI = 1'b0;
         wait_clk(HALF);
         SCLK = 1'b1;
         wait_clk(HALF);
      end
      rst = 1'b1;
      SS_n = 1'b1;
      MOSI = 1'b1;
      wait_clk(4);
      chk("midframe_rst_miso", {15'd0, MISO}, 16'h0000);
      rst = 1'b0;
      wait_clk(4);
      ld_cell_lft = 12'h5A5;
      xfer(16'h0000, rd_word);
      chk("post_rst_frame", rd_word, 16'h0000);
      xfer(16'h0000, rd_word);
      chk("post_rst_5a5", rd_word, 16'h05A5);

      // Fifteen shifts leave resp[0]=1 in tx_shft[15]; idle SCLK must not move it.
      chk("idle_miso_pre", {15'd0, MISO}, 16'h0001);
      ld_cell_lft = 12'h777;
      for (int i = 0; i < 16; i++) begin
         SCLK = 1'b0;
         MOSI = 1'b1;
         wait_clk(HALF);
         SCLK = 1'b1;
         wait_clk(HALF);
      end
      chk("idle_miso_post", {15'd0, MISO}, 16'h0001);
      xfer(16'h0000, rd_word);
      chk("idle_no_shift", rd_word, 16'h05A5);
      xfer(16'h0000, rd_word);
      chk("ch0_777", rd_word, 16'h0777);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
